// File: rtl/rd_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// rd_port_arbiter_if
//
// Bundles every handshake and bus signal of rd_port_arbiter. The signal names
// keep the arbiter's point of view: *_i are driven into the arbiter and *_o
// are driven by it.
//
// Handshake rule, used on all three channels (requester address,
// register-file address, response): a transfer happens in a cycle where valid
// and ready are both high. The arbiter's valid and ready outputs are
// combinational, so a transfer can complete in the same cycle the request
// appears.
//
// Signal groups:
//   req_*      NUM_REQ requester address channels. Addresses are packed;
//              requester k uses [k*ADDR_W +: ADDR_W]. req_last_i marks the
//              final beat of a burst.
//   rd_addr_*  shared read-address port to the register file.
//   rd_data_*  in-order read data returning from the register file.
//   rsp_*      response channel to the requesters. rsp_valid_o is one-hot
//              and rsp_data_o is shared by all requesters.
//   busy_o     a burst lock is held or reads are outstanding.
//   err_o      sticky flag: read data arrived with no read outstanding.
//
// Modports:
//   slave   the arbiter side.
//   master  the requesters and register file, or a testbench standing in
//           for them.
// ----------------------------------------------------------------------------
interface rd_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        req_last_i;

  logic                      rd_addr_valid_o;
  logic                      rd_addr_ready_i;
  logic [ADDR_W-1:0]         rd_addr_o;

  logic                      rd_data_valid_i;
  logic [DATA_W-1:0]         rd_data_i;
  logic                      rd_data_ready_o;

  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic [NUM_REQ-1:0]        rsp_ready_i;

  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_last_i,
    input  rd_addr_ready_i,
    input  rd_data_valid_i, rd_data_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rd_addr_valid_o, rd_addr_o,
    output rd_data_ready_o,
    output rsp_valid_o, rsp_data_o,
    output busy_o, err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_last_i,
    output rd_addr_ready_i,
    output rd_data_valid_i, rd_data_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rd_addr_valid_o, rd_addr_o,
    input  rd_data_ready_o,
    input  rsp_valid_o, rsp_data_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/rd_port_arbiter.sv
// ----------------------------------------------------------------------------
// rd_port_arbiter
//
// Lets NUM_REQ operand-address sequencers share the single register-file
// read-address port.
//
// Arbitration is round-robin, one burst at a time. Once a requester's first
// beat is accepted, it holds the port until its beat marked last is accepted.
// This keeps the operand reads of one micro-instruction contiguous.
//
// An in-order tag FIFO stores the owner of every issued address. Returning
// read data is steered to the requester at the head of that FIFO.
//
// Both the address path and the response path are purely combinational. The
// only registers are the FSM state, the burst owner, the round-robin pointer,
// the tag FIFO and the error flag.
//
// Ports:
//   clk_i            clock
//   srst_i           synchronous reset, active-high
//   bus              rd_port_arbiter_if.slave (all handshake and bus signals)
//   dbg_locked_o     FSM state: 1 = a burst lock is held
//   dbg_rr_ptr_o     round-robin search start
//   dbg_owner_o      requester holding, or last holding, the burst lock
//   dbg_tag_count_o  number of outstanding reads
// ----------------------------------------------------------------------------
module rd_port_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 32,
  parameter  int TAG_DEPTH = 8,
  localparam int SEL_W     = $clog2(NUM_REQ),
  localparam int PTR_W     = $clog2(TAG_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  rd_port_arbiter_if.slave     bus,
  output logic                 dbg_locked_o,
  output logic [SEL_W-1:0]     dbg_rr_ptr_o,
  output logic [SEL_W-1:0]     dbg_owner_o,
  output logic [CNT_W-1:0]     dbg_tag_count_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] sel_idle;
  logic             sel_idle_found;
  logic [SEL_W-1:0] sel;
  logic             sel_found;
  logic [SEL_W-1:0] sel_next;
  logic             sel_last;
  logic             fire;

  logic [SEL_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             tag_full;
  logic             tag_empty;
  logic [SEL_W-1:0] head;
  logic             push;
  logic             pop;

  logic             err_q;

  // Index 'off' positions after 'base', wrapping at NUM_REQ. NUM_REQ need not
  // be a power of two, so the wrap is explicit rather than relying on
  // pointer overflow.
  function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  // Round-robin search: the first valid requester at or after rr_ptr.
  // When no requester is valid, sel_idle falls back to rr_ptr, and
  // sel_idle_found stays low so nothing is granted.
  always_comb begin
    sel_idle       = rr_ptr_q;
    sel_idle_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_idle_found && bus.req_valid_i[rr_index(rr_ptr_q, i)]) begin
        sel_idle       = rr_index(rr_ptr_q, i);
        sel_idle_found = 1'b1;
      end
    end
  end

  // While a burst is locked, only the owner is considered, even if it has
  // dropped valid. There is no preemption.
  assign sel       = (state_q == ST_LOCKED) ? owner_q : sel_idle;
  assign sel_found = (state_q == ST_LOCKED) || sel_idle_found;
  assign sel_last  = bus.req_last_i[sel];
  assign sel_next  = rr_index(sel, 1);

  // Full is taken from the registered count only. A pop in this cycle
  // unblocks a push one cycle later, which keeps the address-valid path
  // independent of the response handshake.
  assign tag_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem[rd_ptr_q];

  assign fire = bus.rd_addr_valid_o && bus.rd_addr_ready_i;
  assign push = fire;
  assign pop  = bus.rd_data_valid_i && bus.rd_data_ready_o && !tag_empty;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Only an accepted beat changes anything. rr_ptr moves
  // only when a burst ends, to the requester just after the one that
  // finished.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      case (state_q)
        ST_IDLE: begin
          if (sel_last) begin
            rr_ptr_d = sel_next;
          end else begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end
        end
        ST_LOCKED: begin
          if (sel_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = sel_next;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (address forwarding and response routing)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.req_ready_o     = '0;
    bus.rd_addr_o       = bus.req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
    bus.rd_addr_valid_o = sel_found && bus.req_valid_i[sel] && !tag_full;
    if (sel_found) begin
      bus.req_ready_o[sel] = bus.rd_addr_ready_i && !tag_full;
    end

    // With no read outstanding, data is still accepted so that the
    // register file cannot stall. The data is dropped and err_o records it.
    bus.rsp_valid_o = '0;
    if (!tag_empty) begin
      bus.rsp_valid_o[head] = bus.rd_data_valid_i;
    end
    bus.rd_data_ready_o = tag_empty ? 1'b1 : bus.rsp_ready_i[head];
    bus.rsp_data_o      = bus.rd_data_i;

    bus.busy_o = (state_q == ST_LOCKED) || !tag_empty;
    bus.err_o  = err_q;
  end

  // --------------------------------------------------------------------------
  // Tag FIFO. The pointers wrap naturally because TAG_DEPTH is a power of
  // two. A push and a pop in the same cycle leave the count unchanged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The storage needs no reset: entries are only read while the count
  // says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_q] <= sel;
  end

  // Sticky error flag: read data arrived while no read was outstanding.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_q <= 1'b0;
    end else if (bus.rd_data_valid_i && tag_empty) begin
      err_q <= 1'b1;
    end
  end

  assign dbg_locked_o    = (state_q == ST_LOCKED);
  assign dbg_rr_ptr_o    = rr_ptr_q;
  assign dbg_owner_o     = owner_q;
  assign dbg_tag_count_o = count_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rd_port_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (burst lock flag, round-robin start and a queue of owner
// tags) predicts every output in every cycle.
// ----------------------------------------------------------------------------
module tb_rd_port_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 8;

  // --------------------------------------------------------------------------
  // Clock and reset
  // --------------------------------------------------------------------------
  logic clk_i = 1'b0;
  logic srst_i;
  always #5 clk_i = ~clk_i;

  rd_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic       dbg_locked_o;
  logic [1:0] dbg_rr_ptr_o;
  logic [1:0] dbg_owner_o;
  logic [3:0] dbg_tag_count_o;

  rd_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .bus            (bus.slave),
    .dbg_locked_o   (dbg_locked_o),
    .dbg_rr_ptr_o   (dbg_rr_ptr_o),
    .dbg_owner_o    (dbg_owner_o),
    .dbg_tag_count_o(dbg_tag_count_o)
  );

  // --------------------------------------------------------------------------
  // Reference model and scoreboard state
  // --------------------------------------------------------------------------
  int               tests_run    = 0;
  int               tests_failed = 0;
  bit               m_locked;
  int               m_owner;
  int               m_rr;
  bit               m_err;
  int               tag_q[$];
  int               fire_log_sel[$];
  logic [ADDR_W-1:0] fire_log_addr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_sel();
    return m_locked || (|bus.req_valid_i);
  endfunction

  // Granted requester: the lock owner, else the first valid one from m_rr.
  function automatic int pick();
    if (m_locked) return m_owner;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid_i[(m_rr + i) % NUM_REQ]) return (m_rr + i) % NUM_REQ;
    end
    return m_rr;
  endfunction

  task automatic check_outputs();
    int               sel;
    bit               full;
    bit               empty;
    bit               e_avalid;
    logic [NUM_REQ-1:0] e_rdy;
    logic [NUM_REQ-1:0] e_rsp;
    full     = (tag_q.size() == TAG_DEPTH);
    empty    = (tag_q.size() == 0);
    sel      = pick();
    e_avalid = has_sel() && bus.req_valid_i[sel] && !full;
    e_rdy    = '0;
    if (has_sel()) e_rdy[sel] = bus.rd_addr_ready_i && !full;
    e_rsp    = '0;
    if (!empty) e_rsp[tag_q[0]] = bus.rd_data_valid_i;
    check("rd_addr_valid", bus.rd_addr_valid_o, e_avalid);
    if (e_avalid) check("rd_addr", bus.rd_addr_o, bus.req_addr_i[sel*ADDR_W +: ADDR_W]);
    check("req_ready", bus.req_ready_o, e_rdy);
    check("rsp_valid", bus.rsp_valid_o, e_rsp);
    check("rsp_data", bus.rsp_data_o, bus.rd_data_i);
    check("rd_data_ready", bus.rd_data_ready_o, empty ? 1'b1 : bus.rsp_ready_i[tag_q[0]]);
    check("busy", bus.busy_o, m_locked || !empty);
    check("err", bus.err_o, m_err);
    check("dbg_locked", dbg_locked_o, m_locked);
    check("dbg_rr_ptr", dbg_rr_ptr_o, m_rr);
    check("dbg_tag_count", dbg_tag_count_o, tag_q.size());
    if (m_locked) check("dbg_owner", dbg_owner_o, m_owner);
  endtask

  task automatic update_model();
    int sel;
    bit full;
    bit empty;
    bit fire;
    bit pop;
    if (srst_i) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_rr     = 0;
      m_err    = 1'b0;
      tag_q.delete();
      return;
    end
    full  = (tag_q.size() == TAG_DEPTH);
    empty = (tag_q.size() == 0);
    sel   = pick();
    fire  = has_sel() && bus.req_valid_i[sel] && !full && bus.rd_addr_ready_i;
    pop   = 1'b0;
    if (!empty) pop = bus.rd_data_valid_i && bus.rsp_ready_i[tag_q[0]];
    if (bus.rd_data_valid_i && empty) m_err = 1'b1;
    if (pop) void'(tag_q.pop_front());
    if (fire) begin
      tag_q.push_back(sel);
      fire_log_sel.push_back(sel);
      fire_log_addr.push_back(bus.req_addr_i[sel*ADDR_W +: ADDR_W]);
      if (!m_locked) begin
        if (bus.req_last_i[sel]) m_rr = (sel + 1) % NUM_REQ;
        else begin
          m_locked = 1'b1;
          m_owner  = sel;
        end
      end else if (bus.req_last_i[sel]) begin
        m_locked = 1'b0;
        m_rr     = (m_owner + 1) % NUM_REQ;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks. Inputs change just after the rising edge. Outputs are
  // checked on the falling edge, then the model advances.
  // --------------------------------------------------------------------------
  task automatic cycle();
    @(negedge clk_i);
    if (!srst_i) check_outputs();
    update_model();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i     = '0;
    bus.req_addr_i      = '0;
    bus.req_last_i      = '0;
    bus.rd_addr_ready_i = 1'b0;
    bus.rd_data_valid_i = 1'b0;
    bus.rd_data_i       = '0;
    bus.rsp_ready_i     = '0;
  endtask

  task automatic set_req(input int k, input bit v, input logic [ADDR_W-1:0] a, input bit l);
    bus.req_valid_i[k]                = v;
    bus.req_addr_i[k*ADDR_W +: ADDR_W] = a;
    bus.req_last_i[k]                 = l;
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    srst_i = 1'b0;
    settle();
    check("rst_rd_addr_valid", bus.rd_addr_valid_o, 1'b0);
    check("rst_req_ready", bus.req_ready_o, 4'b0000);
    check("rst_rsp_valid", bus.rsp_valid_o, 4'b0000);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_rr_ptr", dbg_rr_ptr_o, 2'd0);
    check("rst_tag_count", dbg_tag_count_o, 4'd0);
    fire_log_sel.delete();
    fire_log_addr.delete();
  endtask

  // Return data for every outstanding read, within a fixed cycle budget.
  task automatic drain();
    bus.req_valid_i     = '0;
    bus.rsp_ready_i     = '1;
    for (int i = 0; i < 40 && tag_q.size() != 0; i++) begin
      bus.rd_data_valid_i = 1'b1;
      bus.rd_data_i       = $urandom;
      cycle();
    end
    bus.rd_data_valid_i = 1'b0;
    settle();
    check("drain_tag_count", dbg_tag_count_o, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int rdy_cnt[NUM_REQ];
    srst_i = 1'b1;
    idle_inputs();
    do_reset();

    // 1) 4-beat burst from req0 while req1 waits with a single-beat burst.
    bus.rd_addr_ready_i = 1'b1;
    set_req(1, 1'b1, 8'h20, 1'b1);
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b1, 8'h10 + 8'(b), b == 3);
      cycle();
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    settle();
    check("t1_rr_after_burst", dbg_rr_ptr_o, 2'd1);
    cycle();
    set_req(1, 1'b0, 8'h00, 1'b0);
    check("t1_fire_count", fire_log_addr.size(), 5);
    for (int i = 0; i < 4; i++) begin
      check("t1_burst_addr", fire_log_addr[i], 8'h10 + 8'(i));
      check("t1_burst_sel", fire_log_sel[i], 0);
    end
    check("t1_req1_addr_cycle5", fire_log_addr[4], 8'h20);
    check("t1_req1_sel_cycle5", fire_log_sel[4], 1);
    drain();

    // 2) Every requester issues single-beat bursts every cycle.
    do_reset();
    bus.rd_addr_ready_i = 1'b1;
    bus.rsp_ready_i     = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      set_req(k, 1'b1, 8'(8'h60 + k), 1'b1);
      rdy_cnt[k] = 0;
    end
    for (int c = 0; c < 8; c++) begin
      bus.rd_data_valid_i = (tag_q.size() != 0);
      settle();
      for (int k = 0; k < NUM_REQ; k++) rdy_cnt[k] += int'(bus.req_ready_o[k]);
      cycle();
    end
    for (int i = 0; i < 5; i++) check("t2_rotation", fire_log_sel[i], i % NUM_REQ);
    for (int k = 0; k < NUM_REQ; k++) check("t2_ready_share", rdy_cnt[k], 2);
    drain();

    // 3) Tag FIFO full: issue stalls, and a pop unblocks a push one cycle later.
    do_reset();
    bus.rd_addr_ready_i = 1'b1;
    set_req(0, 1'b1, 8'h77, 1'b1);
    for (int c = 0; c < 10; c++) cycle();
    settle();
    check("t3_fires_at_full", fire_log_sel.size(), TAG_DEPTH);
    check("t3_addr_valid_full", bus.rd_addr_valid_o, 1'b0);
    check("t3_busy_full", bus.busy_o, 1'b1);
    bus.rd_data_valid_i = 1'b1;
    bus.rsp_ready_i     = '1;
    settle();
    check("t3_no_same_cycle_push", bus.rd_addr_valid_o, 1'b0);
    cycle();
    bus.rd_data_valid_i = 1'b0;
    settle();
    check("t3_count_after_pop", dbg_tag_count_o, 4'd7);
    check("t3_push_next_cycle", bus.rd_addr_valid_o, 1'b1);
    cycle();
    check("t3_fires_after_pop", fire_log_sel.size(), TAG_DEPTH + 1);
    set_req(0, 1'b0, 8'h00, 1'b0);
    drain();

    // 4) Response routing: 3 reads from req2, then 1 read from req0.
    do_reset();
    bus.rd_addr_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_req(2, 1'b1, 8'h30 + 8'(b), b == 2);
      cycle();
    end
    set_req(2, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h40, 1'b1);
    cycle();
    set_req(0, 1'b0, 8'h00, 1'b0);
    bus.rd_data_valid_i = 1'b1;
    bus.rd_data_i       = 32'hA;
    bus.rsp_ready_i     = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("t4_stall_rsp_valid", bus.rsp_valid_o, 4'b0100);
      check("t4_stall_data_ready", bus.rd_data_ready_o, 1'b0);
      cycle();
    end
    bus.rsp_ready_i = '1;
    for (int d = 32'hA; d <= 32'hD; d++) begin
      bus.rd_data_i = d;
      settle();
      check("t4_rsp_valid", bus.rsp_valid_o, (d <= 32'hC) ? 4'b0100 : 4'b0001);
      check("t4_rsp_data", bus.rsp_data_o, d);
      check("t4_data_ready", bus.rd_data_ready_o, 1'b1);
      cycle();
    end
    bus.rd_data_valid_i = 1'b0;
    settle();
    check("t4_busy_done", bus.busy_o, 1'b0);

    // 5) Data with nothing outstanding sets the sticky error.
    do_reset();
    bus.rd_data_valid_i = 1'b1;
    bus.rd_data_i       = $urandom;
    settle();
    check("t5_orphan_ready", bus.rd_data_ready_o, 1'b1);
    check("t5_orphan_rsp_valid", bus.rsp_valid_o, 4'b0000);
    cycle();
    bus.rd_data_valid_i = 1'b0;
    settle();
    check("t5_err_set", bus.err_o, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    check("t5_err_sticky", bus.err_o, 1'b1);
    do_reset();

    // 6) Reset while locked with 3 tags outstanding.
    bus.rd_addr_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_req(1, 1'b1, 8'h50 + 8'(b), 1'b0);
      cycle();
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    settle();
    check("t6_locked", dbg_locked_o, 1'b1);
    check("t6_tags", dbg_tag_count_o, 4'd3);
    srst_i              = 1'b1;
    bus.rd_data_valid_i = 1'b1;
    cycle();
    srst_i = 1'b0;
    settle();
    check("t6_idle", dbg_locked_o, 1'b0);
    check("t6_busy", bus.busy_o, 1'b0);
    check("t6_rr", dbg_rr_ptr_o, 2'd0);
    check("t6_rsp_valid", bus.rsp_valid_o, 4'b0000);
    cycle();
    bus.rd_data_valid_i = 1'b0;
    settle();
    check("t6_err_after_reset", bus.err_o, 1'b1);

    // 7) Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        set_req(k, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      end
      bus.rd_addr_ready_i = ($urandom_range(0, 3) != 0);
      bus.rd_data_valid_i = (tag_q.size() != 0) ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 30) == 0);
      bus.rd_data_i       = $urandom;
      bus.rsp_ready_i     = 4'($urandom_range(0, 15));
      srst_i              = ($urandom_range(0, 199) == 0);
      cycle();
    end
    srst_i = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
- Shares the single register-file read-address port between NUM_REQ operand-address sequencers (addr_fsm instances).
- Arbitration is round-robin at burst granularity. A requester keeps the port from its first address beat through the beat flagged last, so the operand reads of one micro-instruction are never interleaved.
- An in-order tag FIFO records the owner of every issued address and routes the returning read data back to that requester.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- ADDR_W, 8, read-address width
- DATA_W, 32, read-data width
- TAG_DEPTH, 8, maximum outstanding reads (power of two)

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester address valid
- req_ready_o  out  NUM_REQ  per-requester address ready
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies [k*ADDR_W +: ADDR_W]
- req_last_i  in  NUM_REQ  marks the final beat of a burst
- rd_addr_valid_o  out  1  address valid to the register file
- rd_addr_ready_i  in  1  register file accepts the address
- rd_addr_o  out  ADDR_W  forwarded address
- rd_data_valid_i  in  1  read data valid (returned in order)
- rd_data_i  in  DATA_W  read data
- rd_data_ready_o  out  1  read data accepted
- rsp_valid_o  out  NUM_REQ  one-hot response valid
- rsp_data_o  out  DATA_W  shared response data, equal to rd_data_i
- rsp_ready_i  in  NUM_REQ  per-requester response ready
- busy_o  out  1  lock held or tags outstanding
- err_o  out  1  sticky flag: data returned with no outstanding tag

Behaviour:
- Reset values:
  - state IDLE, rr_ptr=0, owner=0
  - tag FIFO empty (rd/wr pointers and count = 0)
  - err_o=0
  - All outputs derived from these are 0: rd_addr_valid_o, req_ready_o, rsp_valid_o, busy_o.
- Reset mid-burst clears the lock and discards outstanding tags immediately. Requesters and the register file are reset together with this block.
- State IDLE:
  - The selected requester is the first k with req_valid_i[k], searching from rr_ptr upward with wrap-around.
  - Selection is combinational, so the address is forwarded in the same cycle.
- State LOCKED: the selected requester is owner only. All other requesters see req_ready_o=0.
- Forwarding and handshake:
  - rd_addr_o = req_addr_i[sel].
  - rd_addr_valid_o = req_valid_i[sel] && !tag_full.
  - req_ready_o[sel] = rd_addr_ready_i && !tag_full; all other bits are 0.
  - A beat fires when rd_addr_valid_o && rd_addr_ready_i.
- Transitions (on a fired beat):
  - IDLE, fire with last=0: go to LOCKED, owner=sel.
  - IDLE, fire with last=1: stay IDLE, rr_ptr=(sel+1) mod NUM_REQ.
  - LOCKED, fire with last=1: go to IDLE, rr_ptr=(owner+1) mod NUM_REQ.
  - LOCKED, fire with last=0: stay LOCKED.
- No preemption: if the owner drops req_valid_i while LOCKED, the lock holds indefinitely.
- rr_ptr changes only at burst end.
- Tag FIFO:
  - Every fired beat pushes sel.
  - tag_full means count==TAG_DEPTH and is computed from the registered count only, with no bypass. A pop in the same cycle does not unblock a push; the push happens in the following cycle.
- Response routing:
  - head = FIFO head tag.
  - rsp_valid_o[head] = rd_data_valid_i && !tag_empty; all other bits are 0.
  - rd_data_ready_o = tag_empty ? 1 : rsp_ready_i[head].
  - Pop occurs on rd_data_valid_i && rd_data_ready_o && !tag_empty.
  - Push and pop in the same cycle leave count unchanged.
- Error case:
  - rd_data_valid_i while tag_empty: the data is dropped (ready=1) and err_o is set.
  - err_o stays set until srst_i.
- busy_o = (state==LOCKED) || !tag_empty.
- Latency: zero-cycle combinational on both the address and response paths. The only registers are state, owner, rr_ptr, tag FIFO and err_o.
- Counter widths:
  - count is $clog2(TAG_DEPTH)+1 bits.
  - FIFO pointers are $clog2(TAG_DEPTH) bits and wrap naturally.

Test Plan:
- Req0 issues a 4-beat burst (0x10,0x11,0x12,0x13 last) while req1 is continuously valid, rd_addr_ready_i=1 → rd_addr_o sequence is 0x10..0x13 with no req1 beat in between. Req1's first beat fires in cycle 5; rr_ptr=1 after the burst.
- All 4 requesters issue single-beat bursts (last=1) every cycle → grants rotate 0,1,2,3,0; each req_ready_o is high exactly 1 cycle in 4.
- TAG_DEPTH=8, no read data returned → after 8 fired beats rd_addr_valid_o=0. Return 1 datum → pop happens; the next push occurs one cycle later, not in the same cycle.
- Requester 2 issues 3 reads followed by requester 0 issuing 1 read; data 0xA,0xB,0xC,0xD returns in order → rsp_valid_o=0b0100 for 0xA..0xC and 0b0001 for 0xD. Holding rsp_ready_i[2]=0 for 2 cycles stalls rd_data_ready_o.
- rd_data_valid_i pulse with no outstanding reads → rd_data_ready_o=1, rsp_valid_o=0, err_o=1 and sticky until srst_i.
- srst_i asserted in LOCKED with 3 tags outstanding → next cycle: state IDLE, busy_o=0, rr_ptr=0, rsp_valid_o=0 even while rd_data_valid_i=1 (err_o sets if data arrives after reset).
